gpio: RTL and testbench
=======================

Name: gpio

Overview:
- Memory-mapped general-purpose I/O block on the SoC CPU bus, selected by the top-level decoder for the 4 KB window at 0xF000_0000.
- Holds per-pin output-enable and output-data registers, and synchronises the input pins.
- Returns read data one cycle after a read command.
- Never stalls; the SoC ties mem_cmd_ready high.

Parameters:
- NR_GPIOS, 8, number of GPIO pins (1..32); register bits at NR_GPIOS and above read 0 and ignore writes.

Ports:
- clk  in  1  system clock
- reset_  in  1  reset, asynchronous and active-low
- mem_cmd_sel  in  1  address-decoder select for this block (combinational, same cycle as the command)
- mem_cmd_valid  in  1  bus command valid
- mem_cmd_wr  in  1  1 = write, 0 = read
- mem_cmd_addr  in  12  byte offset inside the GPIO window
- mem_cmd_wdata  in  32  write data
- mem_rsp_ready  out  1  read response valid, one-cycle pulse
- mem_rsp_rdata  out  32  read response data
- gpio_oe  out  NR_GPIOS  per-pin output enable (1 = drive)
- gpio_do  out  NR_GPIOS  per-pin output value
- gpio_di  in  NR_GPIOS  asynchronous pin inputs

Behaviour:
- Command accepted when mem_cmd_valid && mem_cmd_sel. Neither signal alone has any effect.
- Register decode uses mem_cmd_addr[11:2]; addr[1:0] is ignored. All writes are full 32-bit words; there are no byte enables.
- Register map:
  - 0x000 OE: read/write.
  - 0x004 DO: read/write.
  - 0x008 DI: read-only, synchronised inputs.
  - 0x00C DO_SET: write-1-to-set DO bits; reads 0.
  - 0x010 DO_CLR: write-1-to-clear DO bits; reads 0.
  - 0x014 DO_TGL: write-1-to-toggle DO bits; reads 0.
  - All other offsets read 0; writes to them are ignored.
- Write timing: the register update is visible on gpio_oe/gpio_do at the rising edge that accepts the write. There is no write response; mem_rsp_ready stays 0.
- Read timing:
  - An accepted read in cycle N drives mem_rsp_ready=1 in cycle N+1 only.
  - mem_rsp_rdata in cycle N+1 holds the register value sampled at the edge ending cycle N; unused upper bits are 0.
  - Back-to-back reads produce back-to-back responses.
- mem_rsp_rdata is 0 whenever mem_rsp_ready is 0. It is registered (no combinational path from inputs).
- gpio_di passes through a 2-flop synchroniser; the DI register is the second stage. A pin change is readable in a read accepted 2 clocks later at the earliest.
- gpio_do is driven from the DO register irrespective of gpio_oe. Tristate muxing happens at the top level.
- Reset (reset_=0, asynchronous): gpio_oe=0, gpio_do=0, synchroniser flops=0, mem_rsp_ready=0, mem_rsp_rdata=0.
- Reset asserted while a read is pending cancels the response. After reset release, no spurious mem_rsp_ready is produced.
- A read and a write cannot occur in the same cycle (single bus). A write followed immediately by a read of the same register returns the new value.
- No X may appear on mem_rsp_ready at any time, or on mem_rsp_rdata while mem_rsp_ready=1.

Test Plan:
- Reset, then read 0x000/0x004 -> mem_rsp_ready pulses one cycle after each command; rdata=0x0000_0000; gpio_oe=0x00, gpio_do=0x00.
- Write 0x000=0x0000_00F0, write 0x004=0xFFFF_FFA5 -> gpio_oe=0xF0, gpio_do=0xA5 after each accepting edge; readback of 0x004 returns 0x0000_00A5.
- With DO=0xA5: write 0x00C=0x0A -> DO=0xAF; write 0x010=0x81 -> DO=0x2E; write 0x014=0xFF -> DO=0xD1; reads of 0x00C/0x010/0x014 return 0.
- Drive gpio_di=0x3C, then read 0x008 one cycle later -> returns old value. Read again 2+ cycles after the change -> returns 0x0000_003C.
- Command with valid=1, sel=0 (write 0x004=0x55) -> gpio_do unchanged, no response. Read of 0x100 -> rsp_ready=1, rdata=0.
- Assert reset_ mid-operation with OE=0xFF and a read in flight -> outputs go to 0 immediately, with no response pulse.

Source files
------------

// File: rtl/gpio_if.sv
// CPU bus port of the GPIO block: command channel from the SoC, read response back.
interface gpio_if;
  localparam int unsigned AddrW = 12;
  localparam int unsigned DataW = 32;

  logic             mem_cmd_sel;
  logic             mem_cmd_valid;
  logic             mem_cmd_wr;
  logic [AddrW-1:0] mem_cmd_addr;
  logic [DataW-1:0] mem_cmd_wdata;
  logic             mem_rsp_ready;
  logic [DataW-1:0] mem_rsp_rdata;

  modport master (
    output mem_cmd_sel,
    output mem_cmd_valid,
    output mem_cmd_wr,
    output mem_cmd_addr,
    output mem_cmd_wdata,
    input  mem_rsp_ready,
    input  mem_rsp_rdata
  );

  modport slave (
    input  mem_cmd_sel,
    input  mem_cmd_valid,
    input  mem_cmd_wr,
    input  mem_cmd_addr,
    input  mem_cmd_wdata,
    output mem_rsp_ready,
    output mem_rsp_rdata
  );
endinterface

// File: rtl/gpio.sv
// Memory-mapped GPIO: output-enable/data registers with set/clear/toggle aliases,
// 2-flop input synchroniser, single-cycle-latency read response, never stalls.
module gpio #(
  parameter int unsigned NR_GPIOS = 8
) (
  input  logic                clk,
  input  logic                reset_,
  gpio_if.slave               bus,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di
);

  localparam int unsigned GpioW  = NR_GPIOS;
  localparam int unsigned DataW  = 32;
  localparam int unsigned RegIdxW = 10;

  localparam logic [RegIdxW-1:0] IdxOe    = RegIdxW'(0);
  localparam logic [RegIdxW-1:0] IdxDo    = RegIdxW'(1);
  localparam logic [RegIdxW-1:0] IdxDi    = RegIdxW'(2);
  localparam logic [RegIdxW-1:0] IdxDoSet = RegIdxW'(3);
  localparam logic [RegIdxW-1:0] IdxDoClr = RegIdxW'(4);
  localparam logic [RegIdxW-1:0] IdxDoTgl = RegIdxW'(5);

  logic [GpioW-1:0]   oe_q, oe_d;
  logic [GpioW-1:0]   do_q, do_d;
  logic [GpioW-1:0]   di_meta_q;
  logic [GpioW-1:0]   di_q;
  logic               rsp_ready_q, rsp_ready_d;
  logic [DataW-1:0]   rdata_q, rdata_d;

  logic               cmd_acc_c;
  logic               wr_acc_c;
  logic               rd_acc_c;
  logic [RegIdxW-1:0] reg_idx_c;
  logic [GpioW-1:0]   wbits_c;
  logic               unused_addr_lsb_c;

  // Command decode; the byte lane bits of the address carry no meaning.
  assign cmd_acc_c         = bus.mem_cmd_valid && bus.mem_cmd_sel;
  assign wr_acc_c          = cmd_acc_c && bus.mem_cmd_wr;
  assign rd_acc_c          = cmd_acc_c && !bus.mem_cmd_wr;
  assign reg_idx_c         = bus.mem_cmd_addr[11:2];
  assign wbits_c           = GpioW'(bus.mem_cmd_wdata);
  assign unused_addr_lsb_c = ^bus.mem_cmd_addr[1:0];

  // Register writes and read-response generation.
  always_comb begin
    oe_d        = oe_q;
    do_d        = do_q;
    rsp_ready_d = 1'b0;
    rdata_d     = '0;

    if (wr_acc_c) begin
      unique case (reg_idx_c)
        IdxOe:    oe_d = wbits_c;
        IdxDo:    do_d = wbits_c;
        IdxDoSet: do_d = do_q | wbits_c;
        IdxDoClr: do_d = do_q & ~wbits_c;
        IdxDoTgl: do_d = do_q ^ wbits_c;
        default:  ;
      endcase
    end

    if (rd_acc_c) begin
      rsp_ready_d = 1'b1;
      unique case (reg_idx_c)
        IdxOe:   rdata_d = DataW'(oe_q);
        IdxDo:   rdata_d = DataW'(do_q);
        IdxDi:   rdata_d = DataW'(di_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      oe_q        <= '0;
      do_q        <= '0;
      di_meta_q   <= '0;
      di_q        <= '0;
      rsp_ready_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      oe_q        <= oe_d;
      do_q        <= do_d;
      di_meta_q   <= gpio_di;
      di_q        <= di_meta_q;
      rsp_ready_q <= rsp_ready_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gpio_oe           = oe_q;
  assign gpio_do           = do_q;
  assign bus.mem_rsp_ready = rsp_ready_q;
  assign bus.mem_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio: register-map behavioural model checked every cycle,
// plus literal expectations at the key points of the sequence.
module tb_gpio;
  localparam int unsigned NR = 8;
  localparam logic [31:0] MASK = 32'((64'd1 << NR) - 64'd1);

  logic          clk;
  logic          reset_;
  logic [NR-1:0] gpio_oe;
  logic [NR-1:0] gpio_do;
  logic [NR-1:0] gpio_di;

  gpio_if bus ();

  gpio #(.NR_GPIOS(NR)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .bus     (bus),
    .gpio_oe (gpio_oe),
    .gpio_do (gpio_do),
    .gpio_di (gpio_di)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: architectural registers plus the input samples taken at recent edges.
  logic [31:0] m_oe = '0, m_do = '0;
  logic [31:0] di_s1 = '0, di_s2 = '0;
  logic        e_rdy = 1'b0;
  logic [31:0] e_rdata = '0;

  function automatic logic [31:0] model_read(input logic [9:0] w);
    case (w)
      10'd0:   return m_oe;
      10'd1:   return m_do;
      10'd2:   return di_s2;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_oe = '0; m_do = '0; di_s1 = '0; di_s2 = '0;
      e_rdy = 1'b0; e_rdata = '0;
    end else begin
      logic [9:0]  w;
      logic [31:0] d;
      w = bus.mem_cmd_addr[11:2];
      d = bus.mem_cmd_wdata & MASK;
      e_rdy = 1'b0;
      e_rdata = '0;
      if (bus.mem_cmd_valid && bus.mem_cmd_sel) begin
        if (!bus.mem_cmd_wr) begin
          e_rdy = 1'b1;
          e_rdata = model_read(w);
        end else begin
          case (w)
            10'd0:   m_oe = d;
            10'd1:   m_do = d;
            10'd3:   m_do = m_do | d;
            10'd4:   m_do = m_do & ~d;
            10'd5:   m_do = m_do ^ d;
            default: ;
          endcase
        end
      end
      di_s2 = di_s1;
      di_s1 = 32'(gpio_di);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_oe",    32'(gpio_oe), m_oe);
    check("cyc_do",    32'(gpio_do), m_do);
    check("cyc_rdy",   32'(bus.mem_rsp_ready), 32'(e_rdy));
    check("cyc_rdata", bus.mem_rsp_rdata, e_rdata);
  end

  // Drive one command for one cycle; returns #1 after the edge that sees it.
  task automatic cmd(input logic sel, input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    bus.mem_cmd_valid = 1'b1;
    bus.mem_cmd_sel   = sel;
    bus.mem_cmd_wr    = wr;
    bus.mem_cmd_addr  = addr;
    bus.mem_cmd_wdata = wd;
    @(posedge clk); #1;
    bus.mem_cmd_valid = 1'b0;
    bus.mem_cmd_sel   = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
    cmd(1'b1, 1'b1, addr, wd);
    check("wr_no_rsp", 32'(bus.mem_rsp_ready), 32'h0);
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    cmd(1'b1, 1'b0, addr, 32'h0);
    check({name, "_rdy"}, 32'(bus.mem_rsp_ready), 32'h1);
    check(name, bus.mem_rsp_rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_ = 1'b0;
    gpio_di = '0;
    bus.mem_cmd_valid = 1'b0;
    bus.mem_cmd_sel   = 1'b0;
    bus.mem_cmd_wr    = 1'b0;
    bus.mem_cmd_addr  = '0;
    bus.mem_cmd_wdata = '0;
    idle(2);
    check("rst_oe",  32'(gpio_oe), 32'h0);
    check("rst_do",  32'(gpio_do), 32'h0);
    check("rst_rdy", 32'(bus.mem_rsp_ready), 32'h0);
    reset_ = 1'b1;
    idle(1);

    rd("rd_oe_rst", 12'h000, 32'h0);
    rd("rd_do_rst", 12'h004, 32'h0);
    idle(1);
    check("rsp_one_pulse", 32'(bus.mem_rsp_ready), 32'h0);

    wr(12'h000, 32'h0000_00F0);
    check("oe_f0", 32'(gpio_oe), 32'h0000_00F0);
    wr(12'h004, 32'hFFFF_FFA5);
    check("do_a5", 32'(gpio_do), 32'h0000_00A5);
    rd("rd_do_a5", 12'h004, 32'h0000_00A5);
    rd("rd_oe_f0", 12'h000, 32'h0000_00F0);

    wr(12'h00C, 32'h0000_000A);
    check("do_set", 32'(gpio_do), 32'h0000_00AF);
    wr(12'h010, 32'h0000_0081);
    check("do_clr", 32'(gpio_do), 32'h0000_002E);
    wr(12'h014, 32'h0000_00FF);
    check("do_tgl", 32'(gpio_do), 32'h0000_00D1);
    rd("rd_set", 12'h00C, 32'h0);
    rd("rd_clr", 12'h010, 32'h0);
    rd("rd_tgl", 12'h014, 32'h0);

    gpio_di = 8'h3C;
    idle(1);
    rd("rd_di_old", 12'h008, 32'h0);
    rd("rd_di_new", 12'h008, 32'h0000_003C);
    rd("rd_di_lsb", 12'h00A, 32'h0000_003C);

    cmd(1'b0, 1'b1, 12'h004, 32'h0000_0055);
    check("nosel_do",  32'(gpio_do), 32'h0000_00D1);
    check("nosel_rdy", 32'(bus.mem_rsp_ready), 32'h0);
    bus.mem_cmd_sel = 1'b1; bus.mem_cmd_wr = 1'b0; bus.mem_cmd_addr = 12'h004;
    idle(1);
    bus.mem_cmd_sel = 1'b0;
    check("novalid_rdy", 32'(bus.mem_rsp_ready), 32'h0);
    rd("rd_unmapped", 12'h100, 32'h0);
    wr(12'h100, 32'hFFFF_FFFF);
    check("unmapped_wr_do", 32'(gpio_do), 32'h0000_00D1);

    wr(12'h001, 32'h0000_00FF);
    check("oe_ff", 32'(gpio_oe), 32'h0000_00FF);

    // Reset lands while a read command waits for its accepting edge.
    bus.mem_cmd_valid = 1'b1; bus.mem_cmd_sel = 1'b1;
    bus.mem_cmd_wr = 1'b0; bus.mem_cmd_addr = 12'h000;
    #2 reset_ = 1'b0;
    #1;
    check("arst_oe",  32'(gpio_oe), 32'h0);
    check("arst_do",  32'(gpio_do), 32'h0);
    check("arst_rdy", 32'(bus.mem_rsp_ready), 32'h0);
    @(posedge clk); #1;
    bus.mem_cmd_valid = 1'b0; bus.mem_cmd_sel = 1'b0;
    check("arst_hold_rdy", 32'(bus.mem_rsp_ready), 32'h0);
    reset_ = 1'b1;
    idle(2);
    check("post_rst_rdy", 32'(bus.mem_rsp_ready), 32'h0);

    // Reset lands while a response is on the bus.
    wr(12'h000, 32'h0000_0033);
    rd("rd_oe_33", 12'h000, 32'h0000_0033);
    reset_ = 1'b0;
    #1;
    check("arst2_rdy",   32'(bus.mem_rsp_ready), 32'h0);
    check("arst2_rdata", bus.mem_rsp_rdata, 32'h0);
    check("arst2_oe",    32'(gpio_oe), 32'h0);
    idle(1);
    reset_ = 1'b1;
    idle(2);
    rd("rd_di_after_rst", 12'h008, 32'h0000_003C);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
